// File: rtl/micro_sequencer_if.sv
// Purpose: bundles fetch handshake, control-store programming and micro-op outputs of the sequencer.
// Latency: none, wiring only.
// Backpressure: inst_ready (slave->master) gates opcode acceptance; micro-op outputs have no ready.
interface micro_sequencer_if #(
    parameter int OP_W   = 4,
    parameter int STEP_W = 2,
    parameter int ALU_W  = 8,
    parameter int CTRL_W = 16
);
    logic                        prog_we;
    logic [OP_W+STEP_W-1:0]      prog_addr;
    logic [ALU_W+CTRL_W:0]       prog_data;
    logic                        inst_valid;
    logic                        inst_ready;
    logic [OP_W-1:0]             opcode;
    logic                        stall;
    logic                        uop_valid;
    logic [ALU_W-1:0]            alu_flags;
    logic [CTRL_W-1:0]           ctrl_flags;
    logic [STEP_W-1:0]           step;
    logic                        busy;

    modport master (
        output prog_we, prog_addr, prog_data, inst_valid, opcode, stall,
        input  inst_ready, uop_valid, alu_flags, ctrl_flags, step, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, inst_valid, opcode, stall,
        output inst_ready, uop_valid, alu_flags, ctrl_flags, step, busy
    );
endinterface

// File: rtl/micro_sequencer.sv
// Purpose: plays a programmable per-opcode micro-op sequence, one registered micro-op per cycle.
// Latency: 1 cycle from opcode accept to step-0 micro-op on the outputs; back-to-back without bubble.
// Backpressure: stall freezes the current micro-op and drops inst_ready; opcodes accepted only on the last step.
module micro_sequencer #(
    parameter int OP_W   = 4,
    parameter int STEP_W = 2,
    parameter int ALU_W  = 8,
    parameter int CTRL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    micro_sequencer_if.slave   bus
);
    localparam int ADDR_W = OP_W + STEP_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ENT_W  = 1 + ALU_W + CTRL_W;

    // A store entry left unprogrammed behaves as a single-step NOP.
    localparam logic [ENT_W-1:0]  NOP_ENTRY = {1'b1, {(ENT_W-1){1'b0}}};
    localparam logic [STEP_W-1:0] LAST_STEP = {STEP_W{1'b1}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_n;
    logic [OP_W-1:0]     op_q, op_n;
    logic [STEP_W-1:0]   step_q, step_n;
    logic                valid_q, valid_n;
    logic                last_q, last_n;
    logic [ALU_W-1:0]    alu_q, alu_n;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_n;

    logic [ENT_W-1:0]    store [DEPTH];
    logic [ADDR_W-1:0]   rd_addr;
    logic [ENT_W-1:0]    rd_ent;
    logic [STEP_W-1:0]   step_inc;
    logic                cur_last;
    logic                accept;

    // The final step always ends the sequence so step can never wrap back to 0 mid-sequence.
    assign cur_last      = last_q | (step_q == LAST_STEP);
    assign bus.inst_ready = (state_q == IDLE) | ((state_q == RUN) & cur_last & ~bus.stall);
    assign accept        = bus.inst_valid & bus.inst_ready;
    assign step_inc      = step_q + STEP_W'(1);

    // A newly accepted opcode reads its step 0; otherwise the next step of the running opcode.
    assign rd_addr = accept ? {bus.opcode, {STEP_W{1'b0}}} : {op_q, step_inc};
    assign rd_ent  = store[rd_addr];

    // Control store: written any cycle; reads this edge still see the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= NOP_ENTRY;
            end
        end else if (bus.prog_we) begin
            store[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Sequencer state and registered micro-op outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            alu_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            step_q  <= step_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            alu_q   <= alu_n;
            ctrl_q  <= ctrl_n;
        end
    end

    // Next-state: start, advance, chain the next opcode, or retire to IDLE with NOP outputs.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        step_n  = step_q;
        valid_n = valid_q;
        last_n  = last_q;
        alu_n   = alu_q;
        ctrl_n  = ctrl_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = RUN;
                    op_n    = bus.opcode;
                    step_n  = '0;
                    valid_n = 1'b1;
                    last_n  = rd_ent[ENT_W-1];
                    alu_n   = rd_ent[ALU_W+CTRL_W-1:CTRL_W];
                    ctrl_n  = rd_ent[CTRL_W-1:0];
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (!cur_last) begin
                        step_n = step_inc;
                        last_n = rd_ent[ENT_W-1];
                        alu_n  = rd_ent[ALU_W+CTRL_W-1:CTRL_W];
                        ctrl_n = rd_ent[CTRL_W-1:0];
                    end else if (accept) begin
                        op_n   = bus.opcode;
                        step_n = '0;
                        last_n = rd_ent[ENT_W-1];
                        alu_n  = rd_ent[ALU_W+CTRL_W-1:CTRL_W];
                        ctrl_n = rd_ent[CTRL_W-1:0];
                    end else begin
                        state_n = IDLE;
                        step_n  = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        alu_n   = '0;
                        ctrl_n  = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.uop_valid  = valid_q;
    assign bus.alu_flags  = alu_q;
    assign bus.ctrl_flags = ctrl_q;
    assign bus.step       = step_q;
    assign bus.busy       = (state_q == RUN);
endmodule

// File: tb/tb_micro_sequencer.sv
// Purpose: directed self-checking bench for micro_sequencer.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: stall and back-to-back opcode scenarios exercised explicitly.
module tb_micro_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    micro_sequencer_if #(.OP_W(4), .STEP_W(2), .ALU_W(8), .CTRL_W(16)) bus ();

    micro_sequencer #(.OP_W(4), .STEP_W(2), .ALU_W(8), .CTRL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic prog(input logic [5:0] a, input logic [24:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0h exp 0", bus.uop_valid); end
        checks++; if (bus.alu_flags !== 8'h00 || bus.ctrl_flags !== 16'h0000) begin fails++; $display("FAIL rst_flags got %0h/%0h exp 0/0", bus.alu_flags, bus.ctrl_flags); end
        checks++; if (bus.step !== 2'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rst_step_busy got %0h/%0h exp 0/0", bus.step, bus.busy); end
        checks++; if (bus.inst_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0h exp 1", bus.inst_ready); end
        // Default store: opcode 3 is a one-cycle NOP.
        bus.inst_valid = 1'b1; bus.opcode = 4'h3;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        checks++; if (bus.uop_valid !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL nop_valid got %0h/%0h exp 1/1", bus.uop_valid, bus.busy); end
        checks++; if (bus.alu_flags !== 8'h00 || bus.ctrl_flags !== 16'h0000 || bus.step !== 2'd0) begin fails++; $display("FAIL nop_flags got %0h/%0h/%0h exp 0/0/0", bus.alu_flags, bus.ctrl_flags, bus.step); end
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0 || bus.inst_ready !== 1'b1) begin fails++; $display("FAIL nop_end got %0h/%0h exp 0/1", bus.uop_valid, bus.inst_ready); end
    endtask

    task automatic test_two_step;
        prog(6'h0C, {1'b0, 8'h2C, 16'h0000});
        prog(6'h0D, {1'b1, 8'h00, 16'h0040});
        bus.inst_valid = 1'b1; bus.opcode = 4'h3;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        checks++; if (bus.alu_flags !== 8'h2C || bus.ctrl_flags !== 16'h0000 || bus.step !== 2'd0 || bus.uop_valid !== 1'b1) begin fails++; $display("FAIL two_s0 got %0h/%0h/%0h/%0h exp 2c/0/0/1", bus.alu_flags, bus.ctrl_flags, bus.step, bus.uop_valid); end
        checks++; if (bus.inst_ready !== 1'b0) begin fails++; $display("FAIL two_s0_ready got %0h exp 0", bus.inst_ready); end
        @(negedge clk);
        checks++; if (bus.alu_flags !== 8'h00 || bus.ctrl_flags !== 16'h0040 || bus.step !== 2'd1 || bus.uop_valid !== 1'b1) begin fails++; $display("FAIL two_s1 got %0h/%0h/%0h/%0h exp 0/40/1/1", bus.alu_flags, bus.ctrl_flags, bus.step, bus.uop_valid); end
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ctrl_flags !== 16'h0000 || bus.step !== 2'd0) begin fails++; $display("FAIL two_idle got %0h/%0h/%0h/%0h exp 0/0/0/0", bus.uop_valid, bus.busy, bus.ctrl_flags, bus.step); end
    endtask

    task automatic test_back_to_back;
        prog(6'h04, {1'b1, 8'h11, 16'h0001});
        bus.inst_valid = 1'b1; bus.opcode = 4'h3;
        @(negedge clk);
        bus.opcode = 4'h1;
        checks++; if (bus.alu_flags !== 8'h2C || bus.step !== 2'd0 || bus.inst_ready !== 1'b0) begin fails++; $display("FAIL b2b_s0 got %0h/%0h/%0h exp 2c/0/0", bus.alu_flags, bus.step, bus.inst_ready); end
        @(negedge clk);
        checks++; if (bus.ctrl_flags !== 16'h0040 || bus.step !== 2'd1 || bus.inst_ready !== 1'b1) begin fails++; $display("FAIL b2b_s1 got %0h/%0h/%0h exp 40/1/1", bus.ctrl_flags, bus.step, bus.inst_ready); end
        @(negedge clk);
        bus.inst_valid = 1'b0;
        checks++; if (bus.uop_valid !== 1'b1 || bus.alu_flags !== 8'h11 || bus.ctrl_flags !== 16'h0001 || bus.step !== 2'd0) begin fails++; $display("FAIL b2b_op1 got %0h/%0h/%0h/%0h exp 1/11/1/0", bus.uop_valid, bus.alu_flags, bus.ctrl_flags, bus.step); end
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %0h/%0h exp 0/0", bus.uop_valid, bus.busy); end
    endtask

    task automatic test_stall;
        bus.inst_valid = 1'b1; bus.opcode = 4'h3;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        @(negedge clk);
        bus.stall = 1'b1;
        #1;
        checks++; if (bus.inst_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got %0h exp 0", bus.inst_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.ctrl_flags !== 16'h0040 || bus.step !== 2'd1 || bus.uop_valid !== 1'b1 || bus.inst_ready !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got %0h/%0h/%0h/%0h exp 40/1/1/0", c, bus.ctrl_flags, bus.step, bus.uop_valid, bus.inst_ready); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.inst_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %0h exp 1", bus.inst_ready); end
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL stall_resume got %0h/%0h exp 0/0", bus.uop_valid, bus.busy); end
    endtask

    task automatic test_forced_end;
        logic [7:0]  ea;
        logic [15:0] ec;
        for (int i = 0; i < 4; i++) begin
            ea = 8'h50 + 8'(i);
            ec = 16'h0100 << i;
            prog(6'h14 + 6'(i), {1'b0, ea, ec});
        end
        bus.inst_valid = 1'b1; bus.opcode = 4'h5;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = 8'h50 + 8'(i);
            ec = 16'h0100 << i;
            checks++; if (bus.step !== 2'(i) || bus.alu_flags !== ea || bus.ctrl_flags !== ec || bus.uop_valid !== 1'b1) begin fails++; $display("FAIL force_s%0d got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/1", i, bus.step, bus.alu_flags, bus.ctrl_flags, bus.uop_valid, i, ea, ec); end
            if (i < 4) @(negedge clk);
        end
        checks++; if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0 || bus.step !== 2'd0) begin fails++; $display("FAIL force_end got %0h/%0h/%0h exp 0/0/0", bus.uop_valid, bus.busy, bus.step); end
    endtask

    task automatic test_async_reset;
        prog(6'h18, {1'b0, 8'hA0, 16'h1000});
        prog(6'h19, {1'b0, 8'hA1, 16'h2000});
        prog(6'h1A, {1'b1, 8'hA2, 16'h4000});
        bus.inst_valid = 1'b1; bus.opcode = 4'h6;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.step !== 2'd1 || bus.alu_flags !== 8'hA1) begin fails++; $display("FAIL arst_pre got %0h/%0h exp 1/a1", bus.step, bus.alu_flags); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.uop_valid !== 1'b0 || bus.alu_flags !== 8'h00 || bus.ctrl_flags !== 16'h0000 || bus.step !== 2'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL arst_now got %0h/%0h/%0h/%0h/%0h exp 0/0/0/0/0", bus.uop_valid, bus.alu_flags, bus.ctrl_flags, bus.step, bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        bus.inst_valid = 1'b1; bus.opcode = 4'h6;
        @(negedge clk);
        bus.inst_valid = 1'b0;
        checks++; if (bus.uop_valid !== 1'b1 || bus.alu_flags !== 8'h00 || bus.ctrl_flags !== 16'h0000 || bus.step !== 2'd0 || bus.inst_ready !== 1'b1) begin fails++; $display("FAIL arst_nop got %0h/%0h/%0h/%0h/%0h exp 1/0/0/0/1", bus.uop_valid, bus.alu_flags, bus.ctrl_flags, bus.step, bus.inst_ready); end
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL arst_nop_end got %0h/%0h exp 0/0", bus.uop_valid, bus.busy); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst            = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.inst_valid = 1'b0;
        bus.opcode     = '0;
        bus.stall      = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_step();
        test_back_to_back();
        test_stall();
        test_forced_end();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
